// File: rtl/pad_bank_ctrl.sv
// Register-programmed control bank for the user-area bidirectional pads.
// Drives per-pad output/drive/pull configuration and captures synchronised input edges into sticky status.
module pad_bank_ctrl #(
  parameter int NPADS = 43,
  parameter int SYNC  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [4:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ack_o,
  output logic [31:0]      rdata_o,
  output logic             irq_o,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oe,
  output logic [NPADS-1:0] io_ie,
  output logic [NPADS-1:0] io_pu,
  output logic [NPADS-1:0] io_pd,
  output logic [NPADS-1:0] io_cs,
  output logic [NPADS-1:0] io_sl
);

  localparam logic [3:0] R_OUT  = 4'd0;
  localparam logic [3:0] R_OE   = 4'd1;
  localparam logic [3:0] R_IE   = 4'd2;
  localparam logic [3:0] R_PU   = 4'd3;
  localparam logic [3:0] R_PD   = 4'd4;
  localparam logic [3:0] R_CS   = 4'd5;
  localparam logic [3:0] R_SL   = 4'd6;
  localparam logic [3:0] R_IN   = 4'd7;
  localparam logic [3:0] R_RISE = 4'd8;
  localparam logic [3:0] R_FALL = 4'd9;
  localparam logic [3:0] R_STS  = 4'd10;
  localparam logic [3:0] R_SET  = 4'd11;
  localparam logic [3:0] R_CLR  = 4'd12;

  logic [3:0]       reg_sel;
  logic             word_sel;
  logic [NPADS-1:0] wd, wm, rd_full;
  logic [NPADS-1:0] s, p_q, rise, fall, w1c;
  logic [NPADS-1:0] rise_en, fall_en, edge_sts;
  logic [NPADS-1:0] sync_q [SYNC];
  logic [63:0]      rd_ext;

  assign reg_sel  = addr_i[4:1];
  assign word_sel = addr_i[0];

  // Spread the 32-bit write word onto the pad vector; only the addressed word is touched.
  always_comb begin
    for (int i = 0; i < NPADS; i++) begin
      wm[i] = ((i >= 32) == word_sel);
      wd[i] = wdata_i[i % 32] & wm[i];
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~p_q & rise_en & io_ie;
  assign fall = ~s & p_q & fall_en & io_ie;
  assign w1c  = (req_i && we_i && reg_sel == R_STS) ? wd : '0;

  always_comb begin
    rd_full = '0;
    case (reg_sel)
      R_OUT:   rd_full = io_out;
      R_OE:    rd_full = io_oe;
      R_IE:    rd_full = io_ie;
      R_PU:    rd_full = io_pu;
      R_PD:    rd_full = io_pd;
      R_CS:    rd_full = io_cs;
      R_SL:    rd_full = io_sl;
      R_IN:    rd_full = s;
      R_RISE:  rd_full = rise_en;
      R_FALL:  rd_full = fall_en;
      R_STS:   rd_full = edge_sts;
      default: rd_full = '0;
    endcase
  end

  assign rd_ext = 64'(rd_full);

  function automatic logic [NPADS-1:0] merge(input logic [NPADS-1:0] old_v,
                                             input logic [NPADS-1:0] d,
                                             input logic [NPADS-1:0] m);
    return (old_v & ~m) | d;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
      p_q <= s;
    end
  end

  // Bus: req_i is a single-cycle strobe sampled every edge; ack_o follows one cycle later
  // with rdata_o taken from pre-edge state; no stall, so every req gets exactly one ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      rdata_o  <= '0;
      irq_o    <= 1'b0;
      io_out   <= '0;
      io_oe    <= '0;
      io_ie    <= '1;
      io_pu    <= '0;
      io_pd    <= '0;
      io_cs    <= '0;
      io_sl    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      edge_sts <= '0;
    end else begin
      ack_o    <= req_i;
      rdata_o  <= (req_i && !we_i) ? (word_sel ? rd_ext[63:32] : rd_ext[31:0]) : '0;
      irq_o    <= |edge_sts;
      // A new edge in the same cycle as its W1C keeps the bit set.
      edge_sts <= (edge_sts & ~w1c) | rise | fall;
      if (req_i && we_i) begin
        case (reg_sel)
          R_OUT:   io_out  <= merge(io_out, wd, wm);
          R_OE:    io_oe   <= merge(io_oe, wd, wm);
          R_IE:    io_ie   <= merge(io_ie, wd, wm);
          R_PU:    io_pu   <= merge(io_pu, wd, wm);
          R_PD:    io_pd   <= merge(io_pd, wd, wm);
          R_CS:    io_cs   <= merge(io_cs, wd, wm);
          R_SL:    io_sl   <= merge(io_sl, wd, wm);
          R_RISE:  rise_en <= merge(rise_en, wd, wm);
          R_FALL:  fall_en <= merge(fall_en, wd, wm);
          R_SET:   io_out  <= io_out | wd;
          R_CLR:   io_out  <= io_out & ~wd;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Bench for pad_bank_ctrl: random and directed bus traffic and pad toggles against a
// cycle-level reference of the register map, with a queue-based scoreboard on acks.
module tb_pad_bank_ctrl;

  localparam int NPADS = 43;
  localparam int SYNC  = 2;
  localparam logic [63:0] VALID = (64'd1 << NPADS) - 64'd1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             we = 1'b0;
  logic [4:0]       addr = '0;
  logic [31:0]      wdata = '0;
  logic             ack_o;
  logic [31:0]      rdata_o;
  logic             irq_o;
  logic [NPADS-1:0] io_in = '0;
  logic [NPADS-1:0] io_out, io_oe, io_ie, io_pu, io_pd, io_cs, io_sl;

  pad_bank_ctrl #(.NPADS(NPADS), .SYNC(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_o), .rdata_o(rdata_o), .irq_o(irq_o), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .io_ie(io_ie), .io_pu(io_pu), .io_pd(io_pd),
    .io_cs(io_cs), .io_sl(io_sl)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_reg holds each register as a 64-bit pad vector; hist[k] is io_in as sampled k+1 edges ago.
  logic [63:0] m_reg [16];
  logic [63:0] hist[$];
  logic        m_irq = 1'b0;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_reg[r] = '0;
    m_reg[2] = VALID;
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back('0);
    m_irq = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [63:0] s_now, p_now, edges, wm, wd, rd;
    int r;
    s_now = hist[SYNC-1];
    p_now = hist[SYNC];
    edges = ((s_now & ~p_now & m_reg[8]) | (~s_now & p_now & m_reg[9])) & m_reg[2] & VALID;
    r = int'(addr[4:1]);
    wm = (addr[0] ? 64'hFFFFFFFF_00000000 : 64'h00000000_FFFFFFFF) & VALID;
    wd = (addr[0] ? {wdata, 32'h0} : {32'h0, wdata}) & wm;
    m_irq = |m_reg[10];
    if (req) begin
      if (!we) begin
        if (r == 7) rd = s_now;
        else if (r <= 10) rd = m_reg[r];
        else rd = '0;
        exp_q.push_back(addr[0] ? rd[63:32] : rd[31:0]);
      end else begin
        exp_q.push_back(32'h0);
        if (r <= 6 || r == 8 || r == 9) m_reg[r] = (m_reg[r] & ~wm) | wd;
        else if (r == 10) m_reg[10] = m_reg[10] & ~wd;
        else if (r == 11) m_reg[0] = m_reg[0] | wd;
        else if (r == 12) m_reg[0] = m_reg[0] & ~wd;
      end
    end
    m_reg[10] = m_reg[10] | edges;
    hist.push_front(64'(io_in));
    void'(hist.pop_back());
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("io_out", 64'(io_out), m_reg[0]);
    check("io_oe", 64'(io_oe), m_reg[1]);
    check("io_ie", 64'(io_ie), m_reg[2]);
    check("io_pu", 64'(io_pu), m_reg[3]);
    check("io_pd", 64'(io_pd), m_reg[4]);
    check("io_cs", 64'(io_cs), m_reg[5]);
    check("io_sl", 64'(io_sl), m_reg[6]);
    check("irq", 64'(irq_o), 64'(m_irq));
    if (ack_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack act=1 exp=0 t=%0t", $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("rdata", 64'(rdata_o), 64'(e));
      end
    end else begin
      check("rdata_idle", 64'(rdata_o), 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic w, input int r, input int word, input logic [31:0] d);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = {r[3:0], word[0]};
    wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ie_all1", 64'(io_ie), VALID);
    check("rst_out_zero", 64'(io_out), 64'h0);
    check("rst_irq_zero", 64'(irq_o), 64'h0);
    do_req(1'b0, 2, 1, 32'h0);
    idle(2);

    // Output registers and set/clear aliases
    do_req(1'b1, 0, 0, 32'hA5A5A5A5);
    do_req(1'b1, 1, 1, 32'hFFFFFFFF);
    idle(1);
    check("out_w0", 64'(io_out[31:0]), 64'hA5A5A5A5);
    check("oe_w1", 64'(io_oe[42:32]), 64'h7FF);
    do_req(1'b0, 1, 1, 32'h0);
    do_req(1'b1, 11, 0, 32'h2);
    do_req(1'b1, 12, 0, 32'h1);
    idle(1);
    check("out_set_clr", 64'(io_out[1:0]), 64'h2);
    idle(1);

    // Rising edge on pad 0
    do_req(1'b1, 8, 0, 32'h1);
    idle(1);
    io_in[0] = 1'b1;
    idle(1);
    do_req(1'b0, 7, 0, 32'h0);
    idle(2);
    check("irq_after_rise", 64'(irq_o), 64'h1);
    do_req(1'b1, 10, 0, 32'h1);
    idle(2);
    check("irq_after_w1c", 64'(irq_o), 64'h0);

    // Falling edge on pad 42 gated by IE
    do_req(1'b1, 10, 0, 32'hFFFFFFFF);
    do_req(1'b1, 10, 1, 32'hFFFFFFFF);
    do_req(1'b1, 9, 1, 32'h400);
    idle(1);
    io_in[42] = 1'b1;
    idle(4);
    do_req(1'b1, 2, 1, 32'h0);
    idle(1);
    io_in[42] = 1'b0;
    idle(5);
    do_req(1'b0, 10, 1, 32'h0);
    idle(2);
    check("ie_gated_no_irq", 64'(irq_o), 64'h0);
    do_req(1'b1, 2, 1, 32'h7FF);
    idle(1);
    io_in[42] = 1'b1;
    idle(5);
    io_in[42] = 1'b0;
    idle(5);
    do_req(1'b0, 10, 1, 32'h0);
    idle(2);
    check("fall_irq", 64'(irq_o), 64'h1);

    // Edge on pad 5 coinciding with its W1C
    do_req(1'b1, 10, 1, 32'hFFFFFFFF);
    do_req(1'b1, 8, 0, 32'h20);
    do_req(1'b1, 9, 0, 32'h20);
    idle(1);
    io_in[5] = 1'b1;
    idle(5);
    io_in[5] = 1'b0;
    idle(1);
    do_req(1'b1, 10, 0, 32'h20);
    idle(2);
    check("set_wins_irq", 64'(irq_o), 64'h1);
    do_req(1'b0, 10, 0, 32'h0);
    idle(1);

    // Back-to-back reads of regs 0..7
    for (int r = 0; r < 8; r++) do_req(1'b0, r, 0, 32'h0);
    idle(2);

    // Randomised traffic
    do_req(1'b1, 8, 0, 32'hFFFFFFFF);
    do_req(1'b1, 9, 1, 32'hFFFFFFFF);
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), $urandom);
      else
        idle(1);
      if ($urandom_range(0, 2) == 0) io_in[$urandom_range(0, NPADS-1)] ^= 1'b1;
    end
    idle(4);

    // Reset in the middle of a write burst
    do_req(1'b1, 0, 0, 32'hFFFFFFFF);
    do_req(1'b1, 1, 0, 32'hFFFFFFFF);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 1'b0;
    we  = 1'b0;
    #1;
    check("mid_rst_out", 64'(io_out), 64'h0);
    check("mid_rst_oe", 64'(io_oe), 64'h0);
    check("mid_rst_ie", 64'(io_ie), VALID);
    check("mid_rst_ack", 64'(ack_o), 64'h0);
    check("mid_rst_irq", 64'(irq_o), 64'h0);
    check("mid_rst_rdata", 64'(rdata_o), 64'h0);
    idle(2);
    rst = 1'b0;
    idle(6);

    check("acks_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
